// File: rtl/inst_decode_p.sv
// rtl/inst_decode_p.sv - RV32I-class ID stage: decode, forwarding, load-use stall, branch/jump redirect, ID/EX register.
module inst_decode_p #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16,
  parameter bit BP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  input  logic             pred_taken_i,
  input  logic             ex_ready_i,
  output logic             stall_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [XLEN-1:0]  ex_result_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [XLEN-1:0]  mem_result_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_op1_o,
  output logic [XLEN-1:0]  ex_op2_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [2:0]       ex_func3_o,
  output logic [3:0]       ex_alu_ctrl_o,
  output logic             ex_alusrc_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic             ex_memtoreg_o,
  output logic             ex_regwrite_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign rd     = inst_i[11:7];

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  assign imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u32 = {inst_i[31:12], 12'b0};
  assign imm_j32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Forwarding: EX over MEM over register file; x0 always reads the file.
  logic [XLEN-1:0] fwd1, fwd2;
  always_comb begin
    if (ex_regwrite_i && ex_rd_i == rs1 && rs1 != 5'd0)
      fwd1 = ex_result_i;
    else if (mem_regwrite_i && mem_rd_i == rs1 && rs1 != 5'd0)
      fwd1 = mem_result_i;
    else
      fwd1 = rs1_data_i;
    if (ex_regwrite_i && ex_rd_i == rs2 && rs2 != 5'd0)
      fwd2 = ex_result_i;
    else if (mem_regwrite_i && mem_rd_i == rs2 && rs2 != 5'd0)
      fwd2 = mem_result_i;
    else
      fwd2 = rs2_data_i;
  end

  logic            known, use_rs1, use_rs2, is_br, is_jal, is_jalr;
  logic [3:0]      alu_ctrl;
  logic            alusrc, memread, memwrite, memtoreg, regwrite;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, op1, op2;

  always_comb begin
    known    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    alu_ctrl = 4'b0000;
    alusrc   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    imm32    = imm_i32;
    op1      = fwd1;
    op2      = fwd2;
    case (opcode)
      OP_R: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        alu_ctrl = {inst_i[30], f3};
        regwrite = 1'b1;
      end
      OP_IALU: begin
        use_rs1  = 1'b1;
        alu_ctrl = {(f3 == 3'b101) ? inst_i[30] : 1'b0, f3};
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_LOAD: begin
        use_rs1  = 1'b1;
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_STORE: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        alusrc   = 1'b1;
        memwrite = 1'b1;
        imm32    = imm_s32;
      end
      OP_BRANCH: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_br    = 1'b1;
        imm32    = imm_b32;
      end
      OP_JAL: begin
        is_jal   = 1'b1;
        imm32    = imm_j32;
        op1      = pc_i;
        op2      = XLEN'(4);
        regwrite = 1'b1;
      end
      OP_JALR: begin
        use_rs1  = 1'b1;
        is_jalr  = 1'b1;
        op1      = pc_i;
        op2      = XLEN'(4);
        regwrite = 1'b1;
      end
      OP_LUI: begin
        imm32    = imm_u32;
        op1      = '0;
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_AUIPC: begin
        imm32    = imm_u32;
        op1      = pc_i;
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  logic hazard, fire;
  assign hazard = id_valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                  ((use_rs1 & (rs1 == ex_rd_i)) | (use_rs2 & (rs2 == ex_rd_i)));
  assign fire    = id_valid_i & ~hazard & ex_ready_i;
  assign stall_o = id_valid_i & (hazard | ~ex_ready_i);

  logic taken;
  always_comb begin
    case (f3)
      3'b000:  taken = (fwd1 == fwd2);
      3'b001:  taken = (fwd1 != fwd2);
      3'b100:  taken = ($signed(fwd1) <  $signed(fwd2));
      3'b101:  taken = ($signed(fwd1) >= $signed(fwd2));
      3'b110:  taken = (fwd1 <  fwd2);
      3'b111:  taken = (fwd1 >= fwd2);
      default: taken = 1'b0;
    endcase
  end

  logic            pt, redir;
  logic [XLEN-1:0] pc_plus4, pc_imm, jalr_sum;
  assign pt       = BP_EN & pred_taken_i;
  assign pc_plus4 = pc_i + XLEN'(4);
  assign pc_imm   = pc_i + imm;
  assign jalr_sum = fwd1 + imm;

  always_comb begin
    redir         = 1'b0;
    redirect_pc_o = pc_plus4;
    if (is_br) begin
      redir         = taken ^ pt;
      redirect_pc_o = taken ? pc_imm : pc_plus4;
    end else if (is_jal) begin
      redir         = ~pt;
      redirect_pc_o = pc_imm;
    end else if (is_jalr) begin
      redir         = 1'b1;
      redirect_pc_o = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign redirect_o = fire & redir;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, op1_q, op2_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      f3_q;
  logic [3:0]      alu_q;
  logic            alusrc_q, memread_q, memwrite_q, memtoreg_q, regwrite_q;
  logic [CNT_W-1:0] cnt_q;

  // Unknown opcodes fire but are loaded as an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      alu_q      <= '0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (ex_ready_i) begin
      if (fire && known) begin
        valid_q    <= 1'b1;
        pc_q       <= pc_i;
        op1_q      <= op1;
        op2_q      <= op2;
        imm_q      <= imm;
        rs1_q      <= rs1;
        rs2_q      <= rs2;
        rd_q       <= rd;
        f3_q       <= f3;
        alu_q      <= alu_ctrl;
        alusrc_q   <= alusrc;
        memread_q  <= memread;
        memwrite_q <= memwrite;
        memtoreg_q <= memtoreg;
        regwrite_q <= regwrite;
      end else begin
        valid_q    <= 1'b0;
        pc_q       <= '0;
        op1_q      <= '0;
        op2_q      <= '0;
        imm_q      <= '0;
        rs1_q      <= '0;
        rs2_q      <= '0;
        rd_q       <= '0;
        f3_q       <= '0;
        alu_q      <= '0;
        alusrc_q   <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        regwrite_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (redirect_o && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ex_valid_o    = valid_q;
  assign ex_pc_o       = pc_q;
  assign ex_op1_o      = op1_q;
  assign ex_op2_o      = op2_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign ex_func3_o    = f3_q;
  assign ex_alu_ctrl_o = alu_q;
  assign ex_alusrc_o   = alusrc_q;
  assign ex_memread_o  = memread_q;
  assign ex_memwrite_o = memwrite_q;
  assign ex_memtoreg_o = memtoreg_q;
  assign ex_regwrite_o = regwrite_q;
  assign mispred_cnt_o = cnt_q;

endmodule

// File: doc/inst_decode_p.md
Name: inst_decode_p

Overview:
- Parametrised successor to the current ID stage: decodes RV32I-class instructions and resolves branches and JAL/JALR in ID.
- Adds a registered ID/EX pipeline register with valid/ready backpressure, internal load-use hazard detection and bubble injection, and unsigned branch compares.
- Adds a saturating mispredict counter.
- Sits between the IF/ID register and EX; the register file is external, and its read ports are driven from here.

Parameters:
- XLEN, 32, datapath/PC width.
- CNT_W, 16, mispredict counter width.
- BP_EN, 1: 1 = honour pred_taken_i; 0 = treat every prediction as not-taken.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  IF/ID holds a valid instruction.
- pc_i  in  XLEN  PC of the ID instruction.
- inst_i  in  32  instruction.
- pred_taken_i  in  1  fetch predicted taken.
- ex_ready_i  in  1  EX accepts the ID/EX contents.
- stall_o  out  1  hold PC and IF/ID.
- redirect_o  out  1  flush IF/ID and load redirect_pc_o.
- redirect_pc_o  out  XLEN  corrected fetch PC.
- rs1_addr_o, rs2_addr_o  out  5  register-file read addresses, = inst_i[19:15], inst_i[24:20].
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- ex_rd_i  in  5  EX-stage destination register.
- ex_regwrite_i  in  1  EX-stage register write enable.
- ex_memread_i  in  1  EX-stage instruction is a load.
- ex_result_i  in  XLEN  EX-stage result.
- mem_rd_i  in  5  MEM-stage destination register.
- mem_regwrite_i  in  1  MEM-stage register write enable.
- mem_result_i  in  XLEN  MEM-stage result (load data for loads).
- ex_valid_o  out  1  ID/EX register valid.
- ex_pc_o  out  XLEN  registered PC.
- ex_op1_o, ex_op2_o  out  XLEN  registered operands.
- ex_imm_o  out  XLEN  registered immediate.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5  registered register numbers.
- ex_func3_o  out  3  registered func3.
- ex_alu_ctrl_o  out  4  registered ALU control.
- ex_alusrc_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_regwrite_o  out  1  registered controls.
- mispred_cnt_o  out  CNT_W  saturating mispredict/redirect count.

Behaviour:
- Reset: rst low asynchronously clears every registered output and mispred_cnt_o to 0, including mid-stall. The first edge after release behaves as a normal cycle.
- Opcodes:
  - R 0110011: alu_ctrl={f7[5],f3}, regwrite.
  - I-ALU 0010011: alu_ctrl={f3==101?f7[5]:0,f3}, alusrc, regwrite.
  - LOAD 0000011: add, alusrc, memread, memtoreg, regwrite.
  - STORE 0100011: add, alusrc, memwrite.
  - BRANCH 1100011: no writes.
  - JAL 1101111 / JALR 1100111: op1=pc, op2=4, add, regwrite.
  - LUI 0110111: op1=0, alusrc, regwrite.
  - AUIPC 0010111: op1=pc, alusrc, regwrite.
  - Any other opcode is loaded as ex_valid_o=0 with all controls 0.
- Immediate: I/S/B/U/J formats, sign-extended to XLEN. B and J immediates include bit0=0.
- Source use: rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR. rs2 is used by R, STORE, BRANCH.
- Forwarding per source:
  - If ex_regwrite_i and ex_rd_i==rs and rs!=0, take ex_result_i.
  - Else if the same holds for MEM, take mem_result_i.
  - Else take the register-file data.
  - EX has priority over MEM. x0 is never forwarded. The forwarded values feed both the compare and ex_op*_o.
- Hazard: hazard = id_valid_i & ex_memread_i & ex_rd_i!=0 & (used rs1==ex_rd_i | used rs2==ex_rd_i).
- Fire and stall:
  - fire = id_valid_i & ~hazard & ex_ready_i.
  - stall_o = id_valid_i & (hazard | ~ex_ready_i).
- ID/EX register update:
  - ex_ready_i=0: hold all values, whether or not a hazard is present.
  - ex_ready_i=1 and fire: load the decoded instruction.
  - ex_ready_i=1 and no fire: load a bubble (ex_valid_o=0, all enables 0).
- Branch compare on forwarded operands, selected by f3:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - f3 010/011 are never taken.
- Predicted-taken signal: pt = BP_EN & pred_taken_i.
- Redirect (combinational, gated by fire; a stalled instruction never redirects):
  - BRANCH: redirect_o = taken^pt; redirect_pc_o = taken ? pc+imm : pc+4.
  - JAL: redirect_o = ~pt; redirect_pc_o = pc+imm.
  - JALR: redirect_o = 1; redirect_pc_o = (fwd_rs1+imm) & ~1.
  - All others: redirect_o = 0, redirect_pc_o = pc+4.
- Arithmetic: all address arithmetic is modulo 2^XLEN.
- Counter: increments on every clock with redirect_o=1 and saturates at all-ones.

Test Plan:
1. Reset and handshake: hold rst low mid-stream with ex_ready_i=1 -> all outputs 0 immediately. Release, then send ADDI x5,x0,7 at pc=0x100 -> next edge: ex_valid_o=1, ex_rd_o=5, ex_imm_o=7, ex_alusrc_o=1, ex_regwrite_o=1.
2. Load-use: EX holds LW x6 (ex_memread_i=1, ex_rd_i=6); ID holds ADD x7,x6,x1 -> stall_o=1 for exactly one cycle and a bubble is loaded. Next cycle MEM forwards mem_result_i=0x55 -> ex_op1_o=0x55.
3. Forward priority: ex_rd_i=mem_rd_i=3, ex_result_i=0xA, mem_result_i=0xB, ID holds SUB x4,x3,x3 -> ex_op1_o=ex_op2_o=0xA, ex_alu_ctrl_o=4'b1000. Repeat with rs=x0 -> both operands 0.
4. Branch mispredict: BLTU with rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred_taken_i=1 -> not taken: redirect_o=1, redirect_pc_o=0x204, mispred_cnt_o increments by 1. The same operands under BLT -> taken: no redirect.
5. JALR under backpressure: ex_ready_i=0 for 3 cycles with JALR x1,8(x2), x2=0x301 -> redirect_o=0 and ID/EX held throughout. When ex_ready_i rises: redirect_o=1, redirect_pc_o=0x308, ex_op1_o=pc, ex_op2_o=4.
6. Saturation: CNT_W=2, four redirects -> mispred_cnt_o reads 1, 2, 3, 3.
